// File: rtl/issue_queue_select.sv
// rtl/issue_queue_select.sv - issue side of the 16-entry collapsing instruction queue
//
// Holds queue entries (valid, ready, payload) and wakes them up. Each cycle it grants
// up to four of the oldest ready entries and compacts the survivors toward slot 0.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   wr_{1,2}_en_i/addr_i/data_i/rdy_i
//                                 new-instruction writes (addresses in compacted space)
//   wake_mask_i                   per-slot wakeup, pre-compaction index
//   iss_stall_i                   suppress all grants this cycle
//   iss_{1..4}_vld_o/data_o/addr_o
//                                 grants in age order, thermometer valid
//   ins_out_{1..4}_o              copies of iss_k_vld_o for the allocator
//   occupancy_o                   registered count of valid entries
//   err_overflow_o                sticky illegal-write flag
module issue_queue_select #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_1_en_i,
  input  logic [PTR_W-1:0]  wr_1_addr_i,
  input  logic [DATA_W-1:0] wr_1_data_i,
  input  logic              wr_1_rdy_i,
  input  logic              wr_2_en_i,
  input  logic [PTR_W-1:0]  wr_2_addr_i,
  input  logic [DATA_W-1:0] wr_2_data_i,
  input  logic              wr_2_rdy_i,
  input  logic [DEPTH-1:0]  wake_mask_i,
  input  logic              iss_stall_i,
  output logic              iss_1_vld_o,
  output logic [DATA_W-1:0] iss_1_data_o,
  output logic [PTR_W-1:0]  iss_1_addr_o,
  output logic              iss_2_vld_o,
  output logic [DATA_W-1:0] iss_2_data_o,
  output logic [PTR_W-1:0]  iss_2_addr_o,
  output logic              iss_3_vld_o,
  output logic [DATA_W-1:0] iss_3_data_o,
  output logic [PTR_W-1:0]  iss_3_addr_o,
  output logic              iss_4_vld_o,
  output logic [DATA_W-1:0] iss_4_data_o,
  output logic [PTR_W-1:0]  iss_4_addr_o,
  output logic              ins_out_1_o,
  output logic              ins_out_2_o,
  output logic              ins_out_3_o,
  output logic              ins_out_4_o,
  output logic [PTR_W:0]    occupancy_o,
  output logic              err_overflow_o
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W:0]    occ_q, occ_d;
  logic              err_q, err_d;

  // Grant selection
  logic [DEPTH-1:0]  grant;
  logic [2:0]        gnt_cnt;
  logic [3:0]        g_vld;
  logic [PTR_W-1:0]  g_addr [4];
  logic [DATA_W-1:0] g_data [4];

  // Next-state helpers
  logic [DEPTH-1:0]  ready_w;
  logic [2:0]        below;
  logic [PTR_W-1:0]  dst;
  logic [PTR_W:0]    surv;
  logic [PTR_W:0]    tail2;
  logic              w1_ok, w2_ok;

  // Scan from the oldest slot; the k-th hit goes to grant k, which keeps the
  // grant vector thermometer-coded.
  always_comb begin
    grant   = '0;
    gnt_cnt = 3'd0;
    g_vld   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      g_addr[k] = '0;
      g_data[k] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ready_q[i] && !iss_stall_i && (gnt_cnt < 3'd4)) begin
        grant[i]              = 1'b1;
        g_vld[gnt_cnt[1:0]]   = 1'b1;
        g_addr[gnt_cnt[1:0]]  = PTR_W'(i);
        g_data[gnt_cnt[1:0]]  = data_q[i];
        gnt_cnt               = gnt_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    valid_d = '0;
    ready_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = '0;
    end
    below = 3'd0;
    dst   = '0;

    // Wakeups only stick to occupied slots; granted slots vanish below anyway.
    ready_w = ready_q | (wake_mask_i & valid_q);

    // Each survivor slides down by the number of grants beneath it.
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        below = below + 3'd1;
      end else if (valid_q[i]) begin
        dst          = PTR_W'(i) - PTR_W'(below);
        valid_d[dst] = 1'b1;
        ready_d[dst] = ready_w[i];
        data_d[dst]  = data_q[i];
      end
    end

    surv = occ_q - {{(PTR_W-2){1'b0}}, gnt_cnt};

    // A write is accepted only exactly at the compacted tail; anything else
    // (occupied target, gap, full queue, lone wr_2) is dropped and flagged.
    w1_ok = wr_1_en_i && ({1'b0, wr_1_addr_i} == surv) && !valid_d[wr_1_addr_i];
    tail2 = surv + {{PTR_W{1'b0}}, w1_ok};
    w2_ok = wr_2_en_i && w1_ok && ({1'b0, wr_2_addr_i} == tail2) && !valid_d[wr_2_addr_i];

    if (w1_ok) begin
      valid_d[wr_1_addr_i] = 1'b1;
      ready_d[wr_1_addr_i] = wr_1_rdy_i;
      data_d[wr_1_addr_i]  = wr_1_data_i;
    end
    if (w2_ok) begin
      valid_d[wr_2_addr_i] = 1'b1;
      ready_d[wr_2_addr_i] = wr_2_rdy_i;
      data_d[wr_2_addr_i]  = wr_2_data_i;
    end

    occ_d = tail2 + {{PTR_W{1'b0}}, w2_ok};
    err_d = err_q | (wr_1_en_i & ~w1_ok) | (wr_2_en_i & ~w2_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ready_q <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  // Payload needs no reset: it is never observed while its valid bit is clear.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      data_q[i] <= data_d[i];
    end
  end

  assign iss_1_vld_o    = g_vld[0];
  assign iss_2_vld_o    = g_vld[1];
  assign iss_3_vld_o    = g_vld[2];
  assign iss_4_vld_o    = g_vld[3];
  assign iss_1_addr_o   = g_addr[0];
  assign iss_2_addr_o   = g_addr[1];
  assign iss_3_addr_o   = g_addr[2];
  assign iss_4_addr_o   = g_addr[3];
  assign iss_1_data_o   = g_data[0];
  assign iss_2_data_o   = g_data[1];
  assign iss_3_data_o   = g_data[2];
  assign iss_4_data_o   = g_data[3];
  assign ins_out_1_o    = g_vld[0];
  assign ins_out_2_o    = g_vld[1];
  assign ins_out_3_o    = g_vld[2];
  assign ins_out_4_o    = g_vld[3];
  assign occupancy_o    = occ_q;
  assign err_overflow_o = err_q;

endmodule
